// File: rtl/alu_result_fifo.sv
// Capture FIFO for 4-bit ALU results: stores each result with its opcode and
// derived zero/carry flags, and hands entries to a slower consumer via valid/ready.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned YW    = 5,
    parameter int unsigned OPW   = 3,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [YW-1:0]  in_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_op,
    output logic [YW-1:0]  out_y,
    output logic           out_zero,
    output logic           out_carry,
    output logic [CW-1:0]  count,
    output logic           overflow
);

    logic [OPW-1:0] op_mem    [DEPTH];
    logic [YW-1:0]  y_mem     [DEPTH];
    logic           zero_mem  [DEPTH];
    logic           carry_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic full, empty, push, pop;
    logic in_zero, in_carry;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Zero looks only at the data nibble; carry is meaningful for arithmetic ops
    // (opcode MSB clear) and forced low for logic ops.
    assign in_zero  = (in_y[YW-2:0] == '0);
    assign in_carry = ~in_op[OPW-1] & in_y[YW-1];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (in_valid && full) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            op_mem[wr_ptr_q]    <= in_op;
            y_mem[wr_ptr_q]     <= in_y;
            zero_mem[wr_ptr_q]  <= in_zero;
            carry_mem[wr_ptr_q] <= in_carry;
        end
    end

    assign out_op    = op_mem[rd_ptr_q];
    assign out_y     = y_mem[rd_ptr_q];
    assign out_zero  = zero_mem[rd_ptr_q];
    assign out_carry = carry_mem[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the FIFO.
module tb_alu_result_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic       out_zero, out_carry, overflow;
    logic [2:0] in_op, out_op;
    logic [4:0] in_y, out_y;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] y;
    } entry_t;

    entry_t q[$];
    bit     m_ovf;

    alu_result_fifo #(.DEPTH(DEPTH), .YW(5), .OPW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_zero(entry_t e);
        return e.y[3:0] == 4'd0;
    endfunction

    function automatic logic exp_carry(entry_t e);
        return (e.op < 3'd4) ? e.y[4] : 1'b0;
    endfunction

    task automatic compare_state();
        entry_t e;
        check("count", count, q.size());
        check("in_ready", in_ready, q.size() != DEPTH);
        check("out_valid", out_valid, q.size() != 0);
        check("overflow", overflow, m_ovf);
        if (q.size() != 0) begin
            e = q[0];
            check("out_y", out_y, e.y);
            check("out_op", out_op, e.op);
            check("out_zero", out_zero, exp_zero(e));
            check("out_carry", out_carry, exp_carry(e));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input bit v, input logic [2:0] op, input logic [4:0] y,
                         input bit r, input bit c);
        bit     do_push, do_pop;
        entry_t e;
        in_valid  = v;
        in_op     = op;
        in_y      = y;
        out_ready = r;
        clear     = c;
        do_push   = v && (q.size() != DEPTH);
        do_pop    = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (v && q.size() == DEPTH) m_ovf = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.op = op;
                e.y  = y;
                q.push_back(e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        compare_state();
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_y      = '0;
        m_ovf     = 1'b0;

        // Reset state is visible before the first clock edge.
        #1;
        compare_state();
        #10;
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic op with carry, then pop it.
        cycle(1, 3'b000, 5'b10011, 0, 0);
        check("t2_y", out_y, 5'b10011);
        check("t2_carry", out_carry, 1'b1);
        check("t2_zero", out_zero, 1'b0);
        check("t2_count", count, 3'd1);
        cycle(0, 3'b000, 5'b00000, 1, 0);
        check("t2_drained", out_valid, 1'b0);

        // Logic op: carry suppressed, zero from low nibble.
        cycle(1, 3'b100, 5'b10000, 0, 0);
        check("t3_zero", out_zero, 1'b1);
        check("t3_carry", out_carry, 1'b0);
        cycle(0, 3'b000, 5'b00000, 1, 0);

        // Overfill: fifth push is dropped and flagged.
        for (int i = 1; i <= 5; i++) cycle(1, 3'b000, 5'(i), 0, 0);
        check("t4_count", count, 3'd4);
        check("t4_ready", in_ready, 1'b0);
        check("t4_overflow", overflow, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_order", out_y, 5'(i));
            cycle(0, 3'b000, 5'b00000, 1, 0);
        end
        check("t4_empty", out_valid, 1'b0);

        // Simultaneous push/pop at count 2, pointers wrap.
        cycle(1, 3'b010, 5'd7, 0, 0);
        cycle(1, 3'b011, 5'd8, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 3'b001, 5'(10 + i), 1, 0);
            check("t5_count", count, 3'd2);
        end

        // Clear beats a concurrent push and drops the sticky overflow.
        cycle(1, 3'b101, 5'd20, 0, 0);
        check("t6_pre_count", count, 3'd3);
        check("t6_pre_ovf", overflow, 1'b1);
        cycle(1, 3'b110, 5'd21, 0, 1);
        check("t6_count", count, 3'd0);
        check("t6_ovf", overflow, 1'b0);
        check("t6_valid", out_valid, 1'b0);

        // Async reset mid-stream.
        cycle(1, 3'b000, 5'd1, 0, 0);
        cycle(1, 3'b000, 5'd2, 0, 0);
        cycle(1, 3'b000, 5'd3, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check("rst_count", count, 3'd0);
        compare_state();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with alternating producer/consumer pressure.
        for (int i = 0; i < 400; i++) begin
            int unsigned pv, pr;
            pv = ((i / 50) % 2 == 0) ? 80 : 30;
            pr = ((i / 50) % 2 == 0) ? 30 : 80;
            cycle($urandom_range(0, 99) < pv, 3'($urandom), 5'($urandom),
                  $urandom_range(0, 99) < pr, $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
